// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the single external memory bus between instruction fetch and the
// memory-stage data requester. The data requester has fixed priority. A grant
// latches the transfer fields, the transfer is held on the bus until bus_ack,
// and the result is returned with a one-cycle ack. A watchdog aborts a
// transfer that waits too long for bus_ack and reports it through err.
module mem_bus_arbiter #(
  // Bus cycles waited for bus_ack before aborting; legal range 1..255.
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction-fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  // Data requester (loads and stores)
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  // External bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // XFER_IF and XFER_MEM remember which requester owns the bus, so the
  // completion path knows whose rdata/ack/err registers to drive.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER_IF  = 2'd1,
    XFER_MEM = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Last watchdog count before an abort; the counter starts at 0 on grant,
  // so a transfer may occupy at most TIMEOUT bus cycles.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  wdog_q;
  logic [7:0]  wdog_d;
  logic        timeout_d;

  logic        bus_req_q;
  logic        bus_we_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;

  logic [31:0] if_rdata_q;
  logic        if_ack_q;
  logic        if_err_q;
  logic [31:0] mem_rdata_q;
  logic        mem_ack_q;
  logic        mem_err_q;

  // Watchdog next count and abort condition; bus_ack in the last permitted
  // cycle still completes normally, so the abort is qualified by !bus_ack.
  always_comb begin
    wdog_d    = wdog_q + 8'd1;
    timeout_d = (wdog_q == WDOG_LAST) && !bus_ack;
  end

  // Arbitration FSM with all bus and requester outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wdog_q      <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'h0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      mem_rdata_q <= 32'd0;
      mem_ack_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Data stage wins over fetch when both request together.
          if (mem_req) begin
            state_q     <= XFER_MEM;
            wdog_q      <= 8'd0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_be_q    <= mem_be;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
          end else if (if_req) begin
            state_q     <= XFER_IF;
            wdog_q      <= 8'd0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'hF;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= 32'd0;
          end
        end

        XFER_IF, XFER_MEM: begin
          if (bus_ack || timeout_d) begin
            // Both completion and abort release the bus immediately.
            state_q     <= DONE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'h0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            if (state_q == XFER_IF) begin
              if_ack_q   <= 1'b1;
              if_err_q   <= !bus_ack;
              if_rdata_q <= bus_ack ? bus_rdata : 32'd0;
            end else begin
              mem_ack_q   <= 1'b1;
              mem_err_q   <= !bus_ack;
              mem_rdata_q <= bus_ack ? bus_rdata : 32'd0;
            end
          end else begin
            wdog_q <= wdog_d;
          end
        end

        DONE: begin
          // One-cycle ack; the gap back to IDLE lets a registered requester
          // drop its req before the next arbitration.
          state_q     <= IDLE;
          if_ack_q    <= 1'b0;
          if_err_q    <= 1'b0;
          if_rdata_q  <= 32'd0;
          mem_ack_q   <= 1'b0;
          mem_err_q   <= 1'b0;
          mem_rdata_q <= 32'd0;
        end

        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_err   = mem_err_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the CPU's single external memory bus between the instruction-fetch requester and the data requester of the memory stage, which services the decoded loads and stores (LB/LH/LW/LBU/LHU/LWL/LWR, SB/SH/SW/SWL/SWR). A request is granted, its address, data and byte enables are latched, and the bus transfer is sequenced to completion. The result is returned to the requester with a one-cycle acknowledge, and a watchdog aborts hung transfers. The block sits between the pipeline's IF/MEM stages and the bus interface.

## Interface
- TIMEOUT, 255: maximum bus cycles waited for bus_ack before abort; legal range 1..255.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word, valid when if_ack
- if_ack  out  1  one-cycle completion pulse to fetch
- if_err  out  1  with if_ack: transfer timed out
- mem_req  in  1  data request; held high until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_be  in  4  byte enables
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data, valid when mem_ack
- mem_ack  out  1  one-cycle completion pulse to data stage
- mem_err  out  1  with mem_ack: transfer timed out
- bus_req  out  1  bus transfer active
- bus_we  out  1  bus write strobe
- bus_be  out  4  bus byte enables
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data, sampled with bus_ack
- bus_ack  in  1  bus completion, one or more cycles after bus_req

## Operation
- States: IDLE, XFER_IF, XFER_MEM, DONE.
- IDLE:
  - mem_req=1 → XFER_MEM; latch mem_addr/mem_we/mem_be/mem_wdata into the bus registers.
  - Otherwise if_req=1 → XFER_IF; latch if_addr, with bus_we=0 and bus_be=4'hF.
  - Fixed priority: data over fetch.
- XFER_*:
  - bus_req=1 and the bus fields are held constant.
  - On bus_ack=1: capture bus_rdata into the granted requester's rdata register, set its ack, and go to DONE.
- Watchdog:
  - The 8-bit counter clears on grant and increments every XFER cycle without bus_ack.
  - If the counter equals TIMEOUT-1 and bus_ack=0: abort. Drop bus_req, set the granted requester's ack and err, leave rdata at 0, and go to DONE.
- DONE: ack/err high for exactly this cycle, bus_req=0, then IDLE unconditionally. This gives a registered requester time to drop its req before the next arbitration.
- Deasserting req mid-transfer is ignored: the transfer completes and ack still pulses.
- bus_we, bus_be, bus_addr and bus_wdata return to 0 in IDLE and DONE.
- For a store, the returned rdata is the value of bus_rdata at ack; the requester ignores it.
- Never more than one ack high per cycle. Never bus_req while in IDLE or DONE.

## Timing
- Reset:
  - Async assert: state=IDLE and counter=0.
  - All outputs go to 0 immediately, including a bus_req that was in flight. A transfer in progress is abandoned with no ack.
  - Deassert: the first arbitration happens at the first rising edge.
- Latency:
  - Req seen in IDLE at edge 0 → bus_req high from cycle 1.
  - bus_ack in cycle k → ack/rdata in cycle k+1 (DONE).
  - IDLE in cycle k+2; the next grant's bus_req is in cycle k+3.
- Throughput: a zero-wait bus gives 3 cycles per transfer.
- Simultaneous events:
  - bus_ack and the timeout in the same cycle: the ack wins, err=0.
  - Both reqs in IDLE: mem granted; fetch is granted in the IDLE that follows mem's DONE if still requesting.
- TIMEOUT=1: abort after the first XFER cycle if bus_ack=0 in that cycle.

## Test plan
- Reset mid-XFER_MEM with bus_req=1 → all outputs 0 immediately, no mem_ack. After release, a pending if_req is granted next edge.
- if_req, if_addr=0x8000_0000, bus_ack in the first bus cycle with bus_rdata=0x2400_0001 → if_ack=1 and if_rdata=0x2400_0001 two cycles after grant. bus_we=0 and bus_be=F during the transfer.
- mem_req and if_req rise together, store addr=0x1000_0004, be=4'b0011, wdata=0xDEAD_BEEF → the mem transfer goes first with those bus fields. The fetch transfer's bus_req starts 3 cycles after mem's bus_ack when the bus waits 0 cycles.
- TIMEOUT=4, mem load with bus_ack never asserted → bus_req high for exactly 4 cycles, then mem_ack=1, mem_err=1, mem_rdata=0; IDLE next cycle.
- TIMEOUT=4, bus_ack in the 4th XFER cycle (the timeout cycle) → normal completion, mem_err=0, rdata captured.
- if_req dropped in the second cycle of an XFER_IF with a 2-wait bus → the transfer still completes, if_ack pulses once, and no new grant follows.
